onehot_decoder_hold: RTL and testbench

ONEHOT_DECODER_HOLD -- requirements
Module: onehot_decoder_hold

---
 rtl/onehot_decoder_hold_pkg.sv | 14 +
 rtl/onehot_decoder_hold_dec3to8.sv | 11 +
 rtl/onehot_decoder_hold.sv | 90 +++++++++
 tb/tb_onehot_decoder_hold.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/onehot_decoder_hold_pkg.sv
// Shared types and widths for the hold-stretched 3-to-8 one-hot decoder.
package onehot_decoder_hold_pkg;

    localparam int unsigned DEFAULT_HOLD_CYCLES = 4;
    localparam int unsigned CODE_W              = 3;
    localparam int unsigned ONEHOT_W            = 8;
    localparam int unsigned CNT_W               = 8;

    typedef enum logic {
        StIdle,
        StHold
    } state_e;

endpackage

// File: rtl/onehot_decoder_hold_dec3to8.sv
// Combinational binary-to-one-hot decode of a 3-bit index.
module dec3to8
    import onehot_decoder_hold_pkg::*;
(
    input  logic [CODE_W-1:0]   code,
    output logic [ONEHOT_W-1:0] onehot
);

    assign onehot = ONEHOT_W'(1) << code;

endmodule

// File: rtl/onehot_decoder_hold.sv
// Accepts a 3-bit code and holds its one-hot decode on dout for HOLD_CYCLES cycles.
module onehot_decoder_hold
    import onehot_decoder_hold_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = DEFAULT_HOLD_CYCLES
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                valid,
    input  logic [CODE_W-1:0]   code,
    output logic                ready,
    output logic [ONEHOT_W-1:0] dout,
    output logic                done,
    output logic                overrun
);

    // Counter is loaded with the number of further cycles to hold after the first.
    localparam logic [CNT_W-1:0] HoldLoad = CNT_W'(HOLD_CYCLES - 1);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [ONEHOT_W-1:0]  dout_q, dout_d;
    logic                 done_q, done_d;
    logic                 overrun_q, overrun_d;
    logic [ONEHOT_W-1:0]  decoded;

    dec3to8 u_dec (
        .code   (code),
        .onehot (decoded)
    );

    // rst_n gates ready so nothing upstream sees a grant during reset.
    assign ready = rst_n && en && (state_q == StIdle);

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        dout_d    = dout_q;
        done_d    = 1'b0;
        overrun_d = valid && !ready;

        if (!en) begin
            state_d = StIdle;
            count_d = '0;
            dout_d  = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (valid) begin
                        state_d = StHold;
                        count_d = HoldLoad;
                        dout_d  = decoded;
                    end
                end
                StHold: begin
                    if (count_q != '0) begin
                        count_d = count_q - 1'b1;
                    end else begin
                        state_d = StIdle;
                        dout_d  = '0;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            count_q   <= '0;
            dout_q    <= '0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            dout_q    <= dout_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
        end
    end

    assign dout    = dout_q;
    assign done    = done_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_onehot_decoder_hold.sv
// Bench for onehot_decoder_hold: directed vectors plus a cycle-level model for two HOLD_CYCLES values.
module tb_onehot_decoder_hold;

    logic       clk;
    logic       rst_n;
    logic       en      [2];
    logic       valid   [2];
    logic [2:0] code    [2];
    logic       ready   [2];
    logic [7:0] dout    [2];
    logic       done    [2];
    logic       overrun [2];

    int vectors     = 0;
    int miscompares = 0;

    // Model: cycles of visible nonzero output still to come, per instance.
    int         hold_cycles [2] = '{4, 1};
    int         hold_left   [2];
    logic [7:0] m_val       [2];
    logic       m_done      [2];
    logic       m_ovr       [2];
    logic       m_rdy       [2];

    logic [7:0] onehot_tab  [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

    onehot_decoder_hold #(.HOLD_CYCLES(4)) dut0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en[0]),
        .valid   (valid[0]),
        .code    (code[0]),
        .ready   (ready[0]),
        .dout    (dout[0]),
        .done    (done[0]),
        .overrun (overrun[0])
    );

    onehot_decoder_hold #(.HOLD_CYCLES(1)) dut1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en[1]),
        .valid   (valid[1]),
        .code    (code[1]),
        .ready   (ready[1]),
        .dout    (dout[1]),
        .done    (done[1]),
        .overrun (overrun[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                hold_left[i] = 0;
                m_val[i]     = 8'h00;
                m_done[i]    = 1'b0;
                m_ovr[i]     = 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                m_rdy[i]  = en[i] && (hold_left[i] == 0);
                m_ovr[i]  = valid[i] && !m_rdy[i];
                m_done[i] = 1'b0;
                if (!en[i]) begin
                    hold_left[i] = 0;
                end else if (hold_left[i] == 0) begin
                    if (valid[i]) begin
                        hold_left[i] = hold_cycles[i];
                        m_val[i]     = onehot_tab[code[i]];
                    end
                end else if (hold_left[i] == 1) begin
                    hold_left[i] = 0;
                    m_done[i]    = 1'b1;
                end else begin
                    hold_left[i] = hold_left[i] - 1;
                end
            end
        end
    end

    // Per-cycle compare, late in the low phase once inputs and outputs have settled.
    always begin
        @(negedge clk);
        #3;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("model_dout%0d", i), dout[i], (hold_left[i] != 0) ? m_val[i] : 8'h00);
            chk($sformatf("model_done%0d", i), 8'(done[i]), 8'(m_done[i]));
            chk($sformatf("model_overrun%0d", i), 8'(overrun[i]), 8'(m_ovr[i]));
            chk($sformatf("model_ready%0d", i), 8'(ready[i]),
                8'(rst_n && en[i] && (hold_left[i] == 0)));
            chk($sformatf("onehot%0d", i), 8'($countones(dout[i]) <= 1), 8'h01);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            en[i]    = 1'b1;
            valid[i] = 1'b1;
            code[i]  = 3'd0;
        end
        code[1] = 3'd6;
        repeat (2) @(negedge clk);
        chk("rst_dout", dout[0], 8'h00);
        chk("rst_ready", 8'(ready[0]), 8'h00);
        chk("rst_done", 8'(done[0]), 8'h00);
        chk("rst_overrun", 8'(overrun[0]), 8'h00);

        // Reset sweep: first edge after release accepts code 0.
        rst_n = 1'b1;
        @(negedge clk);
        valid[0] = 1'b0;
        chk("first_accept", dout[0], 8'h01);
        repeat (3) begin
            @(negedge clk);
            chk("first_hold", dout[0], 8'h01);
        end
        @(negedge clk);
        chk("first_end_dout", dout[0], 8'h00);
        chk("first_done", 8'(done[0]), 8'h01);
        @(negedge clk);
        chk("first_done_once", 8'(done[0]), 8'h00);

        // Code sweep, each new code accepted on the done cycle of the previous hold.
        valid[0] = 1'b1;
        code[0]  = 3'd0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            valid[0] = 1'b0;
            chk("sweep_first", dout[0], onehot_tab[c]);
            repeat (3) begin
                @(negedge clk);
                chk("sweep_hold", dout[0], onehot_tab[c]);
            end
            @(negedge clk);
            chk("sweep_gap", dout[0], 8'h00);
            chk("sweep_done", 8'(done[0]), 8'h01);
            if (c < 7) begin
                valid[0] = 1'b1;
                code[0]  = 3'(c + 1);
            end
        end
        @(negedge clk);

        // Overrun during hold.
        valid[0] = 1'b1;
        code[0]  = 3'd5;
        @(negedge clk);
        valid[0] = 1'b0;
        chk("ovr_hold1", dout[0], 8'h20);
        @(negedge clk);
        valid[0] = 1'b1;
        code[0]  = 3'd2;
        @(negedge clk);
        valid[0] = 1'b0;
        chk("ovr_pulse", 8'(overrun[0]), 8'h01);
        chk("ovr_dout", dout[0], 8'h20);
        @(negedge clk);
        chk("ovr_once", 8'(overrun[0]), 8'h00);
        chk("ovr_hold4", dout[0], 8'h20);
        @(negedge clk);
        chk("ovr_end", dout[0], 8'h00);
        chk("ovr_done", 8'(done[0]), 8'h01);
        @(negedge clk);

        // Abort by dropping en mid-hold.
        valid[0] = 1'b1;
        code[0]  = 3'd7;
        @(negedge clk);
        valid[0] = 1'b0;
        chk("abort_hold1", dout[0], 8'h80);
        @(negedge clk);
        en[0] = 1'b0;
        @(negedge clk);
        chk("abort_dout", dout[0], 8'h00);
        chk("abort_ready", 8'(ready[0]), 8'h00);
        chk("abort_nodone", 8'(done[0]), 8'h00);
        @(negedge clk);
        chk("abort_nodone2", 8'(done[0]), 8'h00);
        chk("abort_ready2", 8'(ready[0]), 8'h00);
        en[0] = 1'b1;
        #1;
        chk("abort_ready_back", 8'(ready[0]), 8'h01);

        // Asynchronous reset between edges mid-hold.
        @(negedge clk);
        valid[0] = 1'b1;
        code[0]  = 3'd4;
        @(negedge clk);
        valid[0] = 1'b0;
        chk("areset_hold1", dout[0], 8'h10);
        #1 rst_n = 1'b0;
        #1;
        chk("areset_dout", dout[0], 8'h00);
        chk("areset_ready", 8'(ready[0]), 8'h00);
        chk("areset_done", 8'(done[0]), 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("areset_nodone", 8'(done[0]), 8'h00);
        end

        // HOLD_CYCLES=1 instance has seen continuous valid with code 6.
        for (int k = 0; k < 4 && dout[1] != 8'h40; k++) @(negedge clk);
        chk("h1_sync", dout[1], 8'h40);
        chk("h1_sync_nodone", 8'(done[1]), 8'h00);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("h1_dout", dout[1], (k % 2 == 0) ? 8'h00 : 8'h40);
            chk("h1_done", 8'(done[1]), (k % 2 == 0) ? 8'h01 : 8'h00);
        end

        @(negedge clk);
        #4;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
